// File: rtl/jk_pkg.sv
// Purpose : shared JK operation encoding and next-state helper for the JK flip-flop bank.
// Latency : n/a (types and a pure function only).
// Backpressure: none; nothing here holds state.
// Optional feature macro used elsewhere in this slice: JKFF_CHANGE_EN.
package jk_pkg;

  // Encoding is exactly {j,k}, so a plain cast of the concatenation yields the op.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_t;

  // Build the operation from the raw J and K bits.
  function automatic jk_op_t jk_op(input logic j, input logic k);
    return jk_op_t'({j, k});
  endfunction

  // Next state of one bit given the operation and the current state.
  function automatic logic jk_next(input jk_op_t op, input logic q_cur);
    logic nxt;
    nxt = q_cur;
    case (op)
      JK_HOLD: nxt = q_cur;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~q_cur;
      default: nxt = q_cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_flip_flop_if.sv
// Purpose : bundles the enable, J/K inputs and q/qn (plus chg when enabled) of a JK bank.
// Latency : n/a (wiring only).
// Backpressure: none; en is a plain clock enable, no handshake.
// Ports   : en, j, k driven by master; q, qn (and chg with JKFF_CHANGE_EN) driven by slave.
// Macro   : JKFF_CHANGE_EN adds the chg signal and its modport entries.
interface jk_flip_flop_if #(
  parameter int unsigned WIDTH = 1
);

  logic             en;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
`ifdef JKFF_CHANGE_EN
  logic [WIDTH-1:0] chg;
`endif

`ifdef JKFF_CHANGE_EN
  modport master (output en, output j, output k, input q, input qn, input chg);
  modport slave  (input en, input j, input k, output q, output qn, output chg);
`else
  modport master (output en, output j, output k, input q, input qn);
  modport slave  (input en, input j, input k, output q, output qn);
`endif

endinterface

// File: rtl/jk_flip_flop_cell.sv
// Purpose : single-bit JK flip-flop with clock enable and async active-high reset.
// Latency : q updates one rising clk edge after j/k/en are sampled; reset is immediate.
// Backpressure: none; en low simply holds the bit.
// Ports   : clk, rst, en, j, k in; q out. RESET_BIT is the value forced while rst is high.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  // Reset is checked first so it dominates en/j/k, including X on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_BIT;
    end else if (en) begin
      q <= jk_next(jk_op(j, k), q);
    end
  end

endmodule

// File: rtl/jk_flip_flop.sv
// Purpose : bank of WIDTH independent JK flip-flops sharing clk, async reset and clock enable.
// Latency : q one rising edge after sampling; qn is the combinational complement of q.
// Backpressure: none; en low holds every bit regardless of j/k.
// Ports   : clk, rst (async, active-high) plain; en/j/k/q/qn through jk_flip_flop_if.slave.
// Macro   : JKFF_CHANGE_EN adds registered chg, one-cycle pulse per bit whenever q[i] changed.
module jk_flip_flop
  import jk_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst,
  jk_flip_flop_if.slave  bus
);

  logic [WIDTH-1:0] q_r;

  // One cell per bit; bits never interact, so each may do a different op on the same edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (bus.en),
      .j   (bus.j[i]),
      .k   (bus.k[i]),
      .q   (q_r[i])
    );
  end

  assign bus.q  = q_r;
  assign bus.qn = ~q_r;

`ifdef JKFF_CHANGE_EN
  // The cells keep their next state private, so it is recomputed here with the same
  // helper. A bit's change flag is set only when the value it is about to load differs
  // from the current one; a set/clear that lands on the same value gives no pulse.
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] chg_r;

  always_comb begin
    q_nxt = q_r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      q_nxt[i] = jk_next(jk_op(bus.j[i], bus.k[i]), q_r[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_r <= '0;
    end else if (bus.en) begin
      chg_r <= q_nxt ^ q_r;
    end else begin
      chg_r <= '0;
    end
  end

  assign bus.chg = chg_r;
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Purpose : directed self-checking bench for jk_flip_flop (1-bit RV=0, 1-bit RV=1, 4-bit).
// Latency : inputs driven 2 ns after a rising edge, outputs sampled 2 ns after the next one.
// Backpressure: none in the design; the bench is purely clock-stepped.
module tb_jk_flip_flop;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  jk_flip_flop_if #(.WIDTH(1)) b1  ();
  jk_flip_flop_if #(.WIDTH(1)) b1r ();
  jk_flip_flop_if #(.WIDTH(4)) b4  ();

  jk_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  jk_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1r (.clk(clk), .rst(rst), .bus(b1r));
  jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Both single-bit instances always see identical stimulus.
  task automatic drive1(input logic en, input logic j, input logic k);
    b1.en = en;  b1.j = j;  b1.k = k;
    b1r.en = en; b1r.j = j; b1r.k = k;
  endtask

  // Check both single-bit instances against hand-computed q values (qn checked too).
  task automatic check1(input string name, input logic exp_q, input logic exp_qr);
    vectors++;
    if (b1.q !== exp_q || b1.qn !== ~exp_q) begin
      miscompares++;
      $display("FAIL %s rv0: q=%b qn=%b expected q=%b qn=%b", name, b1.q, b1.qn, exp_q, ~exp_q);
    end
    vectors++;
    if (b1r.q !== exp_qr || b1r.qn !== ~exp_qr) begin
      miscompares++;
      $display("FAIL %s rv1: q=%b qn=%b expected q=%b qn=%b", name, b1r.q, b1r.qn, exp_qr, ~exp_qr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive1(1'b1, 1'b0, 1'b0);
    b4.en = 1'b1; b4.j = 4'b0000; b4.k = 4'b0000;
    #2;
    check1("reset_before_edge", 1'b0, 1'b1);
    vectors++;
    if (b4.q !== 4'b0000 || b4.qn !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset_w4: q=%b qn=%b expected q=0000 qn=1111", b4.q, b4.qn);
    end
`ifdef JKFF_CHANGE_EN
    vectors++;
    if (b4.chg !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_chg: chg=%b expected 0000", b4.chg);
    end
`endif
    #8;
    rst = 1'b0;
  endtask

  task automatic test_disable();
    drive1(1'b0, 1'b0, 1'b1);
    tick();
    check1("disable_clr", 1'b0, 1'b1);
    drive1(1'b0, 1'b1, 1'b0);
    tick();
    check1("disable_set", 1'b0, 1'b1);
  endtask

  task automatic test_set_toggle();
    drive1(1'b1, 1'b1, 1'b0);
    tick();
    check1("set", 1'b1, 1'b1);
    drive1(1'b1, 1'b1, 1'b1);
    tick();
    check1("toggle_1", 1'b0, 1'b0);
    tick();
    check1("toggle_2", 1'b1, 1'b1);
    tick();
    check1("toggle_3", 1'b0, 1'b0);
  endtask

  task automatic test_clear_hold();
    drive1(1'b1, 1'b1, 1'b0);
    tick();
    check1("preset", 1'b1, 1'b1);
    drive1(1'b1, 1'b0, 1'b1);
    tick();
    check1("clear", 1'b0, 1'b0);
    drive1(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check1("hold", 1'b0, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    drive1(1'b1, 1'b1, 1'b0);
    tick();
    check1("pre_async_set", 1'b1, 1'b1);
    drive1(1'b1, 1'b1, 1'b1);
    tick();
    check1("pre_async_tgl_1", 1'b0, 1'b0);
    tick();
    check1("pre_async_tgl_2", 1'b1, 1'b1);
    // Pulse reset between edges while inputs request a clear.
    #2;
    rst = 1'b1;
    drive1(1'b1, 1'b0, 1'b1);
    #1;
    check1("async_reset_immediate", 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    drive1(1'b1, 1'b1, 1'b1);
    tick();
    check1("after_async_toggle", 1'b1, 1'b0);
    // Reset held across an edge dominates a pending toggle.
    rst = 1'b1;
    tick();
    check1("reset_over_edge", 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    check1("first_edge_after_reset", 1'b1, 1'b0);
  endtask

  task automatic test_multibit();
    // 0000 -> 0101 via bit2/bit0 set, bit3/bit1 clear.
    b4.en = 1'b1; b4.j = 4'b0101; b4.k = 4'b1010;
    tick();
    vectors++;
    if (b4.q !== 4'b0101 || b4.qn !== 4'b1010) begin
      miscompares++;
      $display("FAIL mb_setup: q=%b qn=%b expected q=0101 qn=1010", b4.q, b4.qn);
    end
`ifdef JKFF_CHANGE_EN
    vectors++;
    if (b4.chg !== 4'b0101) begin
      miscompares++;
      $display("FAIL mb_setup_chg: chg=%b expected 0101", b4.chg);
    end
`endif
    // bit3 toggle, bit2 set, bit1 clear, bit0 hold.
    b4.j = 4'b1100; b4.k = 4'b1010;
    tick();
    vectors++;
    if (b4.q !== 4'b1101 || b4.qn !== 4'b0010) begin
      miscompares++;
      $display("FAIL mb_mixed: q=%b qn=%b expected q=1101 qn=0010", b4.q, b4.qn);
    end
`ifdef JKFF_CHANGE_EN
    vectors++;
    if (b4.chg !== 4'b1000) begin
      miscompares++;
      $display("FAIL mb_mixed_chg: chg=%b expected 1000", b4.chg);
    end
`endif
    b4.j = 4'b0000; b4.k = 4'b0000;
    tick();
    vectors++;
    if (b4.q !== 4'b1101) begin
      miscompares++;
      $display("FAIL mb_hold: q=%b expected 1101", b4.q);
    end
`ifdef JKFF_CHANGE_EN
    vectors++;
    if (b4.chg !== 4'b0000) begin
      miscompares++;
      $display("FAIL mb_hold_chg: chg=%b expected 0000", b4.chg);
    end
`endif
    b4.en = 1'b0; b4.j = 4'b1111; b4.k = 4'b1111;
    tick();
    vectors++;
    if (b4.q !== 4'b1101) begin
      miscompares++;
      $display("FAIL mb_disable: q=%b expected 1101", b4.q);
    end
    b4.en = 1'b1;
    tick();
    vectors++;
    if (b4.q !== 4'b0010 || b4.qn !== 4'b1101) begin
      miscompares++;
      $display("FAIL mb_toggle_all: q=%b qn=%b expected q=0010 qn=1101", b4.q, b4.qn);
    end
`ifdef JKFF_CHANGE_EN
    vectors++;
    if (b4.chg !== 4'b1111) begin
      miscompares++;
      $display("FAIL mb_toggle_all_chg: chg=%b expected 1111", b4.chg);
    end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_disable();
    test_set_toggle();
    test_clear_hold();
    test_async_reset();
    test_multibit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
